// File: rtl/store_buffer.sv
// Word-granular store FIFO between MEM stage and data memory; drains head when no load owns the port.
// Loads forward youngest matching entry in 0 cycles; st_ready drops when full (no full pass-through).
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [31:0]              st_pc,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    output logic [31:0]              ld_data,
    output logic                     dm_we,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_wdata,
    output logic [31:0]              dm_pc,
    input  logic [31:0]              dm_rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t          buf_q [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;
    logic            fwd_hit;
    logic [31:0]     fwd_data;

    assign st_ready = (count_q != CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign push     = st_valid && st_ready;
    assign pop      = !ld_valid && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset: validity is defined by head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[tail] <= '{addr: st_addr, data: st_data, pc: st_pc};
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) &&
                (buf_q[head + PW'(i)].addr[31:2] == ld_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_q[head + PW'(i)].data;
            end
        end
    end

    assign ld_data = fwd_hit ? fwd_data : dm_rdata;

    always_comb begin
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        dm_pc    = '0;
        if (ld_valid) begin
            dm_addr = ld_addr;
        end else if (!empty) begin
            dm_we    = 1'b1;
            dm_addr  = buf_q[head].addr;
            dm_wdata = buf_q[head].data;
            dm_pc    = buf_q[head].pc;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a data-memory model and an in-order write scoreboard.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr, st_data, st_pc;
    logic        ld_valid;
    logic [31:0] ld_addr, ld_data;
    logic        dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;
    logic        empty;
    logic [2:0]  count;

    logic [31:0] mem_model [0:255];
    logic [95:0] exp_q [$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
        .dm_rdata(dm_rdata), .empty(empty), .count(count)
    );

    assign dm_rdata = mem_model[dm_addr[9:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory side: every write must match the oldest outstanding expected store.
    always @(negedge clk) begin
        if (!reset && dm_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL unexpected_write: observed=%h/%h/%h expected=none", dm_addr, dm_wdata, dm_pc);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                assert ({dm_addr, dm_wdata, dm_pc} === e) else begin
                    failures++;
                    $error("FAIL write_order: observed=%h expected=%h", {dm_addr, dm_wdata, dm_pc}, e);
                end
            end
            mem_model[dm_addr[9:2]] = dm_wdata;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p, input bit expect_drain);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_pc    = p;
        if (expect_drain) exp_q.push_back({a, d, p});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = '0;
        mem_model[9] = 32'h0000_0099;
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
        ld_valid = 1'b0; ld_addr = '0;
        tick; tick;
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_count", 32'(count), 32'd0);
            check("idle_empty", 32'(empty), 32'd1);
            check("idle_ready", 32'(st_ready), 32'd1);
            check("idle_we", 32'(dm_we), 32'd0);
            tick;
        end

        // Single store drains one cycle later
        drive_store(32'h10, 32'hDEADBEEF, 32'h3004, 1'b1);
        tick;
        st_valid = 1'b0;
        @(negedge clk);
        check("single_count1", 32'(count), 32'd1);
        check("single_we", 32'(dm_we), 32'd1);
        check("single_addr", dm_addr, 32'h10);
        check("single_data", dm_wdata, 32'hDEADBEEF);
        check("single_pc", dm_pc, 32'h3004);
        tick;
        @(negedge clk);
        check("single_count0", 32'(count), 32'd0);
        check("single_mem", mem_model[4], 32'hDEADBEEF);
        check("single_we_off", 32'(dm_we), 32'd0);
        tick;

        // Fill while loads block the port
        ld_valid = 1'b1;
        ld_addr  = 32'h100;
        for (int i = 0; i < 4; i++) begin
            drive_store(32'(i * 4), 32'hA0 + 32'(i), 32'h4000 + 32'(i * 4), 1'b1);
            tick;
        end
        drive_store(32'h14, 32'hA4, 32'h4010, 1'b0);
        @(negedge clk);
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(st_ready), 32'd0);
        check("full_we_blocked", 32'(dm_we), 32'd0);
        tick;
        st_valid = 1'b0;
        ld_valid = 1'b0;
        @(negedge clk);
        check("full_held_off", 32'(count), 32'd4);
        check("full_drain_we", 32'(dm_we), 32'd1);
        check("full_drain_addr", dm_addr, 32'h0);
        tick;
        @(negedge clk);
        check("full_ready_back", 32'(st_ready), 32'd1);
        check("full_count3", 32'(count), 32'd3);
        tick; tick; tick;
        @(negedge clk);
        check("full_drained", 32'(count), 32'd0);
        check("full_mem3", mem_model[3], 32'hA3);

        // Forwarding with drain blocked by loads
        tick;
        ld_valid = 1'b1;
        ld_addr  = 32'h20;
        drive_store(32'h20, 32'h1, 32'h5000, 1'b1);
        @(negedge clk);
        check("fwd_none", ld_data, 32'h0);
        tick;
        drive_store(32'h20, 32'h2, 32'h5004, 1'b1);
        @(negedge clk);
        check("fwd_not_same_cycle", ld_data, 32'h1);
        tick;
        st_valid = 1'b0;
        @(negedge clk);
        check("fwd_youngest", ld_data, 32'h2);
        tick;
        ld_addr = 32'h22;
        @(negedge clk);
        check("fwd_word_match", ld_data, 32'h2);
        tick;
        ld_addr = 32'h24;
        @(negedge clk);
        check("fwd_miss_mem", ld_data, 32'h99);
        check("fwd_miss_addr", dm_addr, 32'h24);
        tick;
        ld_valid = 1'b0;
        tick; tick;
        @(negedge clk);
        check("fwd_drained", 32'(count), 32'd0);
        check("fwd_mem", mem_model[8], 32'h2);
        tick;

        // Push and pop together at count=2
        ld_valid = 1'b1;
        drive_store(32'h30, 32'hB0, 32'h6000, 1'b1);
        tick;
        drive_store(32'h34, 32'hB1, 32'h6004, 1'b1);
        tick;
        ld_valid = 1'b0;
        drive_store(32'h38, 32'hB2, 32'h6008, 1'b1);
        @(negedge clk);
        check("pp_count_before", 32'(count), 32'd2);
        check("pp_head_addr", dm_addr, 32'h30);
        tick;
        st_valid = 1'b0;
        @(negedge clk);
        check("pp_count_same", 32'(count), 32'd2);
        check("pp_next_head", dm_addr, 32'h34);
        tick; tick;
        @(negedge clk);
        check("pp_drained", 32'(count), 32'd0);
        check("pp_tail_mem", mem_model[14], 32'hB2);
        tick;

        // Wrap-around stream of 10 stores
        for (int i = 0; i < 10; i++) begin
            drive_store(32'h40 + 32'(i * 4), 32'hC0 + 32'(i), 32'h7000 + 32'(i * 4), 1'b1);
            tick;
        end
        st_valid = 1'b0;
        for (int k = 0; k < 20 && !empty; k++) tick;
        @(negedge clk);
        check("wrap_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 10; i++) check("wrap_mem", mem_model[16 + i], 32'hC0 + 32'(i));
        tick;

        // Reset with three pending stores
        ld_valid = 1'b1;
        ld_addr  = 32'h200;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h80 + 32'(i * 4), 32'hE0 + 32'(i), 32'h8000, 1'b0);
            tick;
        end
        drive_store(32'h8C, 32'hE3, 32'h8000, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_count3", 32'(count), 32'd3);
        tick;
        reset = 1'b0;
        st_valid = 1'b0;
        ld_valid = 1'b0;
        @(negedge clk);
        check("rst_count0", 32'(count), 32'd0);
        check("rst_we", 32'(dm_we), 32'd0);
        check("rst_ready", 32'(st_ready), 32'd1);
        tick; tick; tick;
        @(negedge clk);
        for (int i = 0; i < 4; i++) check("rst_no_write", mem_model[32 + i], 32'h0);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
